mem_byte_access: RTL
====================

// Module: mem_byte_access
// PURPOSE
//  Memory-access stage for the LC-3b datapath, driving MAR/MDR-style transactions to the memory
//  for LDW/LDB/STW/STB. Latches a request, runs a ready-handshake with memory, then registers
//  read data into MDR. For byte loads it extracts the addressed byte lane onto byte_out, which
//  feeds the zero-/sign-extend units directly downstream. Checks word alignment; memory timeout.
// PARAMETERS
//  TIMEOUT   16   max cycles in ACCESS without mem_ready before aborting with err (1..255)
// PORTS
//  clock      in   1   system clock, all state on rising edge
//  reset      in   1   asynchronous, active-high reset
//  start      in   1   request strobe; sampled only in IDLE
//  we         in   1   1 = store, 0 = load
//  byte_op    in   1   1 = byte access (LDB/STB), 0 = word access (LDW/STW)
//  addr       in   16  byte address
//  wdata      in   16  store data; byte stores use wdata[7:0]
//  busy       out  1   high from cycle after accepted start until done cycle inclusive
//  done       out  1   one-cycle completion pulse
//  err        out  1   valid with done: 1 = unaligned word access or timeout
//  mdr        out  16  last successfully loaded word (raw memory word)
//  byte_out   out  8   addressed byte of last successful load
//  mem_en     out  1   memory request, held until mem_ready or timeout
//  mem_we     out  1   memory write enable, qualified by mem_en
//  mem_wmask  out  2   lane mask {hi,lo}: word = 11, byte = addr[0] ? 10 : 01
//  mem_addr   out  16  {addr[15:1],1'b0} of latched request
//  mem_wdata  out  16  word: wdata; byte: {wdata[7:0],wdata[7:0]}
//  mem_rdata  in   16  memory read data, valid when mem_ready = 1
//  mem_ready  in   1   memory completion, sampled while mem_en = 1
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE; busy, done, err, mem_en, mem_we = 0; mem_wmask = 00;
//    mdr = 0, byte_out = 0, mem_addr = 0, mem_wdata = 0, timeout counter = 0.
//  - All outputs registered. States: IDLE, ACCESS, FAULT, DONE.
//  - IDLE: start=1 latches we/byte_op/addr/wdata. If byte_op=0 and addr[0]=1 -> FAULT, else
//    -> ACCESS with mem_en=1, mem_we=we, mask/addr/wdata as in PORTS, counter cleared.
//  - ACCESS: counter increments each cycle. mem_ready=1 -> DONE, mem_en/mem_we drop next
//    cycle; on a load, mdr <= mem_rdata and byte_out <= byte_op ? (addr[0] ? rdata[15:8]
//    : rdata[7:0]) : rdata[7:0], same edge. Counter reaching TIMEOUT with no ready -> DONE with
//    err=1, mem_en dropped, mdr/byte_out unchanged. Ready on the TIMEOUT cycle wins (success).
//  - FAULT: one cycle, no memory activity (mem_en stays 0) -> DONE with err=1.
//  - DONE: done=1 one cycle, err valid; -> IDLE. busy high in ACCESS/FAULT/DONE.
//  - Latency: start@T -> mem_en@T+1; mem_ready sampled @T+k -> done@T+k+1. Zero-wait memory
//    (ready with mem_en's first cycle) -> done@T+2. Fault: done@T+2.
//  - start while not IDLE ignored, no queueing. start in the DONE cycle ignored; earliest
//    accepted back-to-back start is the cycle after done.
//  - Stores never modify mdr/byte_out. err cleared to 0 on the next accepted start.
//  - reset during ACCESS aborts immediately: mem_en drops asynchronously, no done pulse.
// TESTING
//  - LDW addr=0x3000, rdata=0xBEEF ready after 3 wait cycles -> done@T+5, err=0, mdr=0xBEEF,
//    byte_out=0xEF.
//  - LDB addr=0x3001, rdata=0x80F6, zero-wait -> done@T+2, byte_out=0x80, mask=11, mdr=0x80F6.
//  - STB addr=0x4003, wdata=0x12A5 -> mem_wdata=0xA5A5, mem_wmask=10, mem_addr=0x4002,
//    mem_we=1; mdr unchanged.
//  - LDW addr=0x3001 -> no mem_en ever, done@T+2 with err=1; following LDW succeeds, err=0.
//  - TIMEOUT=16, ready never asserted -> mem_en high 16 cycles, done with err=1, mdr held;
//    repeat with ready on 16th cycle -> err=0.
//  - start pulsed during ACCESS and during DONE -> ignored; reset asserted mid-ACCESS ->
//    all outputs at reset values same cycle, no done.

Source files
------------

// File: rtl/mem_byte_access.sv
// LC-3b memory-access stage: latches an LDW/LDB/STW/STB request, handshakes
// with memory, registers load data into MDR and extracts the addressed byte.
module mem_byte_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic        byte_op,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] mdr,
  output logic [7:0]  byte_out,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_wmask,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    FAULT,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic        lat_we, lat_we_d;
  logic        lat_byte, lat_byte_d;
  logic        lat_lo, lat_lo_d;
  logic        busy_d, done_d, err_d;
  logic        mem_en_d, mem_we_d;
  logic [1:0]  mem_wmask_d;
  logic [15:0] mem_addr_d, mem_wdata_d;
  logic [15:0] mdr_d;
  logic [7:0]  byte_out_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_byte  <= 1'b0;
      lat_lo    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wmask <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mdr       <= '0;
      byte_out  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      lat_we    <= lat_we_d;
      lat_byte  <= lat_byte_d;
      lat_lo    <= lat_lo_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_wmask <= mem_wmask_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mdr       <= mdr_d;
      byte_out  <= byte_out_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    lat_we_d    = lat_we;
    lat_byte_d  = lat_byte;
    lat_lo_d    = lat_lo;
    busy_d      = busy;
    done_d      = 1'b0;
    err_d       = err;
    mem_en_d    = mem_en;
    mem_we_d    = mem_we;
    mem_wmask_d = mem_wmask;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mdr_d       = mdr;
    byte_out_d  = byte_out;

    unique case (state)
      IDLE: begin
        if (start) begin
          lat_we_d   = we;
          lat_byte_d = byte_op;
          lat_lo_d   = addr[0];
          busy_d     = 1'b1;
          err_d      = 1'b0;
          cnt_d      = '0;
          if (!byte_op && addr[0]) begin
            state_d = FAULT;
          end else begin
            state_d     = ACCESS;
            mem_en_d    = 1'b1;
            mem_we_d    = we;
            mem_addr_d  = {addr[15:1], 1'b0};
            mem_wdata_d = byte_op ? {wdata[7:0], wdata[7:0]} : wdata;
            // loads always fetch the full word; only byte stores narrow lanes
            mem_wmask_d = (we && byte_op) ?
                          (addr[0] ? 2'b10 : 2'b01) : 2'b11;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt + 8'd1;
        if (mem_ready) begin
          state_d  = DONE;
          done_d   = 1'b1;
          err_d    = 1'b0;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (!lat_we) begin
            mdr_d      = mem_rdata;
            byte_out_d = (lat_byte && lat_lo) ?
                         mem_rdata[15:8] : mem_rdata[7:0];
          end
        end else if (cnt == LAST) begin
          state_d  = DONE;
          done_d   = 1'b1;
          err_d    = 1'b1;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
        end
      end
      FAULT: begin
        state_d = DONE;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
